// File: rtl/synth_pkg.sv
// synth_pkg: shared types for the synthesiser control path.
//   wave_type_e   - oscillator wave select (saw/square/triangle/reserved)
//   alloc_state_e - voice allocator FSM state
//   age_width()   - width of the per-voice saturating age counter
package synth_pkg;

  typedef enum logic [1:0] {
    SAW      = 2'b00,
    SQUARE   = 2'b01,
    TRIANGLE = 2'b10,
    RESERVED = 2'b11
  } wave_type_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } alloc_state_e;

  // One bit wider than the voice index, so with every voice sounding an
  // age can still tell "older than all the others" apart from a tie.
  function automatic int age_width(input int num_voices);
    return $clog2(num_voices) + 1;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: request, voice-bank and acknowledge signals of the
// voice allocator.
//   Request : ReqValid, ReqReady, ReqNoteOn, ReqFrequency, ReqWaveType
//   Voices  : VoiceFrequency, VoiceWaveType, VoiceGate (packed, voice i at
//             [i*width +: width])
//   Ack     : AckValid, AckIndex, AckStolen, AckDropped
//   Debug   : DbgState (FSM state), DbgAge (packed per-voice age counters)
// Handshake: a request transfers on a rising Clock edge where ReqValid and
// ReqReady are both high; request fields are only sampled on that edge.
// ReqReady stays low until the matching AckValid pulse has been issued.
// modport slave is the allocator side, master the requester side.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int WAVE_DEPTH = 8
);
  import synth_pkg::*;

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int AGE_W = age_width(NUM_VOICES);

  logic                             ReqValid;
  logic                             ReqReady;
  logic                             ReqNoteOn;
  logic [WAVE_DEPTH-1:0]            ReqFrequency;
  logic [1:0]                       ReqWaveType;
  logic [NUM_VOICES*WAVE_DEPTH-1:0] VoiceFrequency;
  logic [NUM_VOICES*2-1:0]          VoiceWaveType;
  logic [NUM_VOICES-1:0]            VoiceGate;
  logic                             AckValid;
  logic [IDX_W-1:0]                 AckIndex;
  logic                             AckStolen;
  logic                             AckDropped;
  logic [1:0]                       DbgState;
  logic [NUM_VOICES*AGE_W-1:0]      DbgAge;

  modport slave (
    input  ReqValid, ReqNoteOn, ReqFrequency, ReqWaveType,
    output ReqReady, VoiceFrequency, VoiceWaveType, VoiceGate,
    output AckValid, AckIndex, AckStolen, AckDropped, DbgState, DbgAge
  );

  modport master (
    output ReqValid, ReqNoteOn, ReqFrequency, ReqWaveType,
    input  ReqReady, VoiceFrequency, VoiceWaveType, VoiceGate,
    input  AckValid, AckIndex, AckStolen, AckDropped, DbgState, DbgAge
  );

endinterface

// File: rtl/voice_slot.sv
// voice_slot: state of one oscillator voice.
//   Clock, ResetN       - clock, asynchronous active-low reset
//   load                - take load_freq/load_wave, gate on, age to 0
//   clear               - gate off (frequency and wave type are kept)
//   age_inc             - increment age, saturating at all-ones
//   freq, wave, gate    - current voice settings
//   age                 - commits since this voice was last (re)triggered
module voice_slot
  import synth_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int AGE_W      = age_width(4)
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  load,
  input  logic                  clear,
  input  logic                  age_inc,
  input  logic [WAVE_DEPTH-1:0] load_freq,
  input  logic [1:0]            load_wave,
  output logic [WAVE_DEPTH-1:0] freq,
  output logic [1:0]            wave,
  output logic                  gate,
  output logic [AGE_W-1:0]      age
);

  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      freq <= '0;
      wave <= '0;
      gate <= 1'b0;
      age  <= '0;
    end else if (load) begin
      freq <= load_freq;
      wave <= load_wave;
      gate <= 1'b1;
      age  <= '0;
    end else begin
      if (clear) gate <= 1'b0;
      if (age_inc && (age != AGE_MAX)) age <= age + 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on/note-off requests to NUM_VOICES
// oscillator slots.
//   Clock, ResetN - clock, asynchronous active-low reset
//   bus           - voice_allocator_if.slave (request, voice bank, ack, debug)
// Each accepted request walks IDLE -> SCAN (NUM_VOICES cycles, one slot per
// cycle from index 0) -> COMMIT (one cycle, Ack pulses, slots update at its
// end) -> IDLE.
// Note-on target: active voice with the same frequency (retrigger), else the
// lowest free voice, else with VOICE_STEAL_EN the oldest active voice.
// Compile-time option: VOICE_STEAL_EN. Without it a full bank drops the
// note-on and AckStolen is always 0.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int WAVE_DEPTH = 8
) (
  input logic              Clock,
  input logic              ResetN,
  voice_allocator_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int AGE_W = age_width(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  alloc_state_e          state;
  logic                  ready_q;
  logic [IDX_W-1:0]      scan_ptr;
  logic                  req_note_on;
  logic [WAVE_DEPTH-1:0] req_freq;
  logic [1:0]            req_wave;

  // scan candidates
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic                  match_found;
  logic [IDX_W-1:0]      match_idx;
`ifdef VOICE_STEAL_EN
  logic                  old_found;
  logic [IDX_W-1:0]      old_idx;
  logic [AGE_W-1:0]      old_age;
`endif

  logic [WAVE_DEPTH-1:0] slot_freq [NUM_VOICES];
  logic [1:0]            slot_wave [NUM_VOICES];
  logic [AGE_W-1:0]      slot_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] slot_gate;
  logic [NUM_VOICES-1:0] slot_load;
  logic [NUM_VOICES-1:0] slot_clear;
  logic [NUM_VOICES-1:0] slot_age_inc;

  logic                  accept;
  logic                  commit;
  logic [IDX_W-1:0]      target;
  logic                  dropped;
  logic                  stolen;

  // ready_q is registered so it stays low through reset and rises on the
  // first edge after release; it is only high while in IDLE.
  assign accept = bus.ReqValid & ready_q;
  assign commit = (state == COMMIT);

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      scan_ptr    <= '0;
      req_note_on <= 1'b0;
      req_freq    <= '0;
      req_wave    <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
`ifdef VOICE_STEAL_EN
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= SCAN;
            ready_q     <= 1'b0;
            scan_ptr    <= '0;
            req_note_on <= bus.ReqNoteOn;
            req_freq    <= bus.ReqFrequency;
            // the reserved wave code is stored as saw
            req_wave    <= (bus.ReqWaveType == 2'(RESERVED)) ? 2'(SAW) : bus.ReqWaveType;
            free_found  <= 1'b0;
            match_found <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_found   <= 1'b0;
`endif
          end else begin
            ready_q <= 1'b1;
          end
        end
        SCAN: begin
          // first-found wins for free and match; oldest uses a strict
          // compare so an age tie keeps the lower index
          if (!slot_gate[scan_ptr]) begin
            if (!free_found) begin
              free_found <= 1'b1;
              free_idx   <= scan_ptr;
            end
          end else begin
            if (!match_found && (slot_freq[scan_ptr] == req_freq)) begin
              match_found <= 1'b1;
              match_idx   <= scan_ptr;
            end
`ifdef VOICE_STEAL_EN
            if (!old_found || (slot_age[scan_ptr] > old_age)) begin
              old_found <= 1'b1;
              old_idx   <= scan_ptr;
              old_age   <= slot_age[scan_ptr];
            end
`endif
          end
          if (scan_ptr == LAST_IDX) state <= COMMIT;
          else scan_ptr <= scan_ptr + 1'b1;
        end
        COMMIT: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Commit decision from the scan results. For note-off, target is the
  // lowest matching voice (reported index); every match is cleared below.
  always_comb begin
    target  = '0;
    dropped = 1'b0;
    stolen  = 1'b0;
    if (req_note_on) begin
      // a zero period would stall the oscillator
      if (req_freq == '0) dropped = 1'b1;
      else if (match_found) target = match_idx;
      else if (free_found) target = free_idx;
`ifdef VOICE_STEAL_EN
      else if (old_found) begin
        target = old_idx;
        stolen = 1'b1;
      end
`endif
      else dropped = 1'b1;
    end else if (match_found) begin
      target = match_idx;
    end else begin
      dropped = 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_slot
    localparam logic [IDX_W-1:0] SLOT_ID = IDX_W'(i);

    assign slot_load[i]    = commit & req_note_on & ~dropped & (target == SLOT_ID);
    assign slot_age_inc[i] = commit & req_note_on & ~dropped & slot_gate[i] & (target != SLOT_ID);
    assign slot_clear[i]   = commit & ~req_note_on & slot_gate[i] & (slot_freq[i] == req_freq);

    voice_slot #(
      .WAVE_DEPTH(WAVE_DEPTH),
      .AGE_W     (AGE_W)
    ) u_slot (
      .Clock    (Clock),
      .ResetN   (ResetN),
      .load     (slot_load[i]),
      .clear    (slot_clear[i]),
      .age_inc  (slot_age_inc[i]),
      .load_freq(req_freq),
      .load_wave(req_wave),
      .freq     (slot_freq[i]),
      .wave     (slot_wave[i]),
      .gate     (slot_gate[i]),
      .age      (slot_age[i])
    );

    assign bus.VoiceFrequency[i*WAVE_DEPTH +: WAVE_DEPTH] = slot_freq[i];
    assign bus.VoiceWaveType[i*2 +: 2]                    = slot_wave[i];
    assign bus.DbgAge[i*AGE_W +: AGE_W]                   = slot_age[i];
  end

  assign bus.VoiceGate  = slot_gate;
  assign bus.ReqReady   = ready_q;
  assign bus.AckValid   = commit;
  assign bus.AckIndex   = commit ? target : '0;
  assign bus.AckStolen  = commit & stolen;
  assign bus.AckDropped = commit & dropped;
  assign bus.DbgState   = state;

endmodule

// File: tb/tb_voice_allocator.sv
module tb_voice_allocator;

  localparam int NV      = 4;
  localparam int WD      = 8;
  localparam int IDX_W   = 2;
  localparam int AGE_W   = 3;
  localparam int AGE_MAX = 7;

  // clock / reset
  logic Clock = 1'b0;
  logic ResetN = 1'b1;
  always #5 Clock = ~Clock;

  voice_allocator_if #(.NUM_VOICES(NV), .WAVE_DEPTH(WD)) bus ();

  voice_allocator #(.NUM_VOICES(NV), .WAVE_DEPTH(WD)) dut (
    .Clock (Clock),
    .ResetN(ResetN),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) cyc++;

  // behavioural model: voice bank as plain arrays, one pending result
  int m_freq [NV] = '{default: 0};
  int m_wave [NV] = '{default: 0};
  int m_gate [NV] = '{default: 0};
  int m_age  [NV] = '{default: 0};
  int p_freq [NV];
  int p_wave [NV];
  int p_gate [NV];
  int p_age  [NV];
  int m_phase = 0;  // 0 idle, 1..NV scanning, NV+1 ack cycle
  bit m_ready = 1'b0;
  bit model_live = 1'b0;
  logic [IDX_W+1:0] exp_q[$];  // {stolen, dropped, index}

  task automatic model_accept(input bit on, input int f, input int w);
    int tgt = -1;
    int best = 0;
    bit drop = 0;
    bit st = 0;
    logic [IDX_W-1:0] idx = '0;
    for (int i = 0; i < NV; i++) begin
      p_freq[i] = m_freq[i]; p_wave[i] = m_wave[i];
      p_gate[i] = m_gate[i]; p_age[i] = m_age[i];
    end
    if (on) begin
      if (f == 0) drop = 1;
      else begin
        for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] != 0 && m_freq[i] == f) tgt = i;
        for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] == 0) tgt = i;
`ifdef VOICE_STEAL_EN
        if (tgt < 0) begin
          for (int i = 1; i < NV; i++) if (m_age[i] > m_age[best]) best = i;
          tgt = best;
          st = 1;
        end
`endif
        if (tgt < 0) drop = 1;
        else begin
          for (int i = 0; i < NV; i++)
            if (i != tgt && m_gate[i] != 0) p_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
          p_gate[tgt] = 1; p_freq[tgt] = f; p_wave[tgt] = (w == 3) ? 0 : w; p_age[tgt] = 0;
          idx = IDX_W'(tgt);
        end
      end
    end else begin
      for (int i = 0; i < NV; i++)
        if (m_gate[i] != 0 && m_freq[i] == f) begin
          if (tgt < 0) tgt = i;
          p_gate[i] = 0;
        end
      if (tgt < 0) drop = 1;
      else idx = IDX_W'(tgt);
    end
    exp_q.push_back({st, drop, idx});
  endtask

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < NV; i++) begin
        m_freq[i] = 0; m_wave[i] = 0; m_gate[i] = 0; m_age[i] = 0;
      end
      m_phase = 0;
      m_ready = 1'b0;
      exp_q.delete();
      model_live = 1'b1;
    end else if (m_phase == NV + 1) begin
      for (int i = 0; i < NV; i++) begin
        m_freq[i] = p_freq[i]; m_wave[i] = p_wave[i]; m_gate[i] = p_gate[i]; m_age[i] = p_age[i];
      end
      m_phase = 0;
      m_ready = 1'b1;
    end else if (m_phase > 0) begin
      m_phase++;
    end else if (m_ready && bus.ReqValid) begin
      model_accept(bus.ReqNoteOn, int'(bus.ReqFrequency), int'(bus.ReqWaveType));
      m_phase = 1;
      m_ready = 1'b0;
    end else begin
      m_ready = 1'b1;
    end
  end

  // scoreboard: compare every cycle on the falling edge
  logic [NV*WD-1:0]    e_freq;
  logic [NV*2-1:0]     e_wave;
  logic [NV-1:0]       e_gate;
  logic [NV*AGE_W-1:0] e_age;
  logic [IDX_W+1:0]    e_ack;

  always @(negedge Clock) begin
    if (model_live) begin
      for (int i = 0; i < NV; i++) begin
        e_freq[i*WD +: WD]       = m_freq[i][WD-1:0];
        e_wave[i*2 +: 2]         = m_wave[i][1:0];
        e_gate[i]                = (m_gate[i] != 0);
        e_age[i*AGE_W +: AGE_W]  = m_age[i][AGE_W-1:0];
      end
      chk("ready", bus.ReqReady, m_ready);
      chk("gate", bus.VoiceGate, e_gate);
      chk("freq", bus.VoiceFrequency, e_freq);
      chk("wave", bus.VoiceWaveType, e_wave);
      chk("age", bus.DbgAge, e_age);
      chk("ack_valid", bus.AckValid, (m_phase == NV + 1));
      if (bus.AckValid) begin
        if (exp_q.size() == 0) chk("ack_unexpected", bus.AckValid, 1'b0);
        else begin
          e_ack = exp_q.pop_front();
          chk("ack_fields", {bus.AckStolen, bus.AckDropped, bus.AckIndex}, e_ack);
        end
      end
    end
  end

  // driver tasks
  task automatic issue(input logic on, input logic [WD-1:0] f, input logic [1:0] w);
    int n = 0;
    @(negedge Clock);
    while (!bus.ReqReady && n < 40) begin
      @(negedge Clock);
      n++;
    end
    chk("ready_wait", bus.ReqReady, 1'b1);
    if (bus.ReqReady) begin
      bus.ReqValid = 1'b1;
      bus.ReqNoteOn = on;
      bus.ReqFrequency = f;
      bus.ReqWaveType = w;
      @(posedge Clock);
      #1;
      acc_cyc = cyc;
      bus.ReqValid = 1'b0;
      // changes after acceptance must be ignored
      bus.ReqNoteOn = 1'($urandom_range(0, 1));
      bus.ReqFrequency = WD'($urandom_range(0, 255));
      bus.ReqWaveType = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic wait_ack(output logic st, output logic dr, output logic [IDX_W-1:0] ix, output int lat);
    int n = 0;
    @(negedge Clock);
    while (!bus.AckValid && n < 4 * NV) begin
      @(negedge Clock);
      n++;
    end
    chk("ack_wait", bus.AckValid, 1'b1);
    st = bus.AckStolen;
    dr = bus.AckDropped;
    ix = bus.AckIndex;
    lat = cyc - acc_cyc;
  endtask

  task automatic send(input logic on, input logic [WD-1:0] f, input logic [1:0] w,
                      output logic st, output logic dr, output logic [IDX_W-1:0] ix, output int lat);
    issue(on, f, w);
    wait_ack(st, dr, ix, lat);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  logic st, dr;
  logic [IDX_W-1:0] ix;
  int lat;

  initial begin
    bus.ReqValid = 1'b0;
    bus.ReqNoteOn = 1'b0;
    bus.ReqFrequency = '0;
    bus.ReqWaveType = '0;

    // reset, then release between edges
    #2 ResetN = 1'b0;
    #1;
    chk("rst_gate", bus.VoiceGate, '0);
    chk("rst_ready", bus.ReqReady, 1'b0);
    chk("rst_ack", {bus.AckValid, bus.AckStolen, bus.AckDropped, bus.AckIndex}, '0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    #2 ResetN = 1'b1;
    #1 chk("rel_ready_low", bus.ReqReady, 1'b0);
    @(posedge Clock);
    #1 chk("rel_ready_high", bus.ReqReady, 1'b1);

    // first note: ack in the cycle ending at edge T+5, voice 0
    send(1'b1, 8'h40, 2'b00, st, dr, ix, lat);
    chk("a1_lat", lat, NV);
    chk("a1_ack", {st, dr, ix}, 4'b0000);
    @(negedge Clock); @(negedge Clock);
    chk("a1_gate", bus.VoiceGate, 4'b0001);
    chk("a1_freq", bus.VoiceFrequency[7:0], 8'h40);

    // fill the bank
    send(1'b1, 8'h50, 2'b01, st, dr, ix, lat);
    chk("a2_idx1", ix, 2'd1);
    send(1'b1, 8'h60, 2'b10, st, dr, ix, lat);
    chk("a2_idx2", ix, 2'd2);
    send(1'b1, 8'h70, 2'b00, st, dr, ix, lat);
    chk("a2_idx3", ix, 2'd3);

    // full bank: voice 0 is the oldest (age 3)
    send(1'b1, 8'h80, 2'b00, st, dr, ix, lat);
    @(negedge Clock); @(negedge Clock);
    chk("a3_gate", bus.VoiceGate, 4'b1111);
`ifdef VOICE_STEAL_EN
    chk("a3_ack", {st, dr, ix}, 4'b1000);
    chk("a3_freq", bus.VoiceFrequency[7:0], 8'h80);
`else
    chk("a3_ack", {st, dr, ix}, 4'b0100);
    chk("a3_freq", bus.VoiceFrequency[7:0], 8'h40);
`endif

    // retrigger 0x50 with triangle
    send(1'b1, 8'h50, 2'b10, st, dr, ix, lat);
    chk("a4_ack", {st, dr, ix}, 4'b0001);
    @(negedge Clock); @(negedge Clock);
    chk("a4_wave", bus.VoiceWaveType[3:2], 2'b10);

    // note-off hit and miss
    send(1'b0, 8'h50, 2'b00, st, dr, ix, lat);
    chk("a5_ack", {st, dr, ix}, 4'b0001);
    @(negedge Clock); @(negedge Clock);
    chk("a5_gate", bus.VoiceGate, 4'b1101);
    send(1'b0, 8'h99, 2'b00, st, dr, ix, lat);
    chk("a5_miss", {st, dr, ix}, 4'b0100);

    // zero frequency dropped, reserved wave stored as saw in free voice 1
    send(1'b1, 8'h00, 2'b01, st, dr, ix, lat);
    chk("a6_zero", {st, dr, ix}, 4'b0100);
    send(1'b1, 8'h20, 2'b11, st, dr, ix, lat);
    chk("a6_ack", {st, dr, ix}, 4'b0001);
    @(negedge Clock); @(negedge Clock);
    chk("a6_wave", bus.VoiceWaveType[3:2], 2'b00);
    chk("a6_freq", bus.VoiceFrequency[15:8], 8'h20);

    // reset in the middle of a scan
    issue(1'b1, 8'h44, 2'b01);
    @(posedge Clock); @(posedge Clock);
    #3 ResetN = 1'b0;
    #1;
    chk("b_gate", bus.VoiceGate, '0);
    chk("b_freq", bus.VoiceFrequency, '0);
    chk("b_wave", bus.VoiceWaveType, '0);
    chk("b_ack", {bus.AckValid, bus.AckStolen, bus.AckDropped, bus.AckIndex}, '0);
    chk("b_ready", bus.ReqReady, 1'b0);
    repeat (NV + 3) @(negedge Clock);
    #2 ResetN = 1'b1;
    #1 chk("b_ready_low", bus.ReqReady, 1'b0);
    @(posedge Clock);
    #1 chk("b_ready_high", bus.ReqReady, 1'b1);

    // randomized traffic, checked by the scoreboard
    for (int k = 0; k < 200; k++) begin
      logic on;
      logic [WD-1:0] f;
      on = ($urandom_range(0, 99) < 65);
      f = ($urandom_range(0, 15) == 0) ? 8'h00 : WD'(8'h10 + $urandom_range(0, 7));
      send(on, f, 2'($urandom_range(0, 3)), st, dr, ix, lat);
      chk("r_lat", lat, NV);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
    end

    repeat (2) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony controller in front of a bank of NUM_VOICES wave_gen oscillators.
- Accepts note-on/note-off requests over a valid/ready handshake and assigns each note to a voice slot.
- Drives each oscillator's Frequency, WaveType and a per-voice gate for the downstream envelope/mixer.
- When no voice is free, steals the oldest active voice (see VOICE_STEAL_EN).

Parameters:
NUM_VOICES, 4, number of oscillator slots, >=2
WAVE_DEPTH, 8, oscillator period/amplitude width; matches wave_gen
IDX_W, $clog2(NUM_VOICES), voice index width (derived, not overridden)

Ports:
Clock  in  1  system clock, rising edge
ResetN  in  1  asynchronous active-low reset
ReqValid  in  1  request present
ReqReady  out  1  allocator can accept
ReqNoteOn  in  1  1=note-on, 0=note-off
ReqFrequency  in  WAVE_DEPTH  oscillator period value (note identity)
ReqWaveType  in  2  00 saw, 01 square, 10 triangle, 11 reserved
VoiceFrequency  out  NUM_VOICES*WAVE_DEPTH  per-voice period, voice i at [i*WAVE_DEPTH +: WAVE_DEPTH]
VoiceWaveType  out  NUM_VOICES*2  per-voice wave type
VoiceGate  out  NUM_VOICES  1=voice sounding
AckValid  out  1  one-cycle pulse, request finished
AckIndex  out  IDX_W  voice affected (note-on); lowest cleared index (note-off)
AckStolen  out  1  with AckValid: an active voice was stolen
AckDropped  out  1  with AckValid: request caused no change

Behaviour:
- Reset (ResetN low, asynchronous): all Voice* = 0, all ages = 0, Ack* = 0, ReqReady = 0, state IDLE. ReqReady rises on the first Clock edge after release. Reset mid-SCAN abandons the request; no Ack is issued.
- FSM states: IDLE, SCAN, COMMIT.
  - IDLE: ReqReady=1. ReqValid&ReqReady latches the request and moves to SCAN.
  - SCAN: exactly NUM_VOICES cycles, one slot examined per cycle, index 0 upward. Records: first free slot; first active slot with equal frequency ("match"); oldest active slot, ties to the lowest index.
  - COMMIT: one cycle. Registers update at its end. AckValid pulses during COMMIT. Next state is IDLE.
- Timing: the request is accepted at edge T; Ack is visible in cycle T+NUM_VOICES+1; new Voice* values are visible from T+NUM_VOICES+2. Throughput is one request per NUM_VOICES+2 cycles.
- Note-on target priority: match (retrigger; wave type updated) > lowest free slot > oldest active slot (steal, AckStolen=1).
  - The target gets gate=1, frequency, wave type, and age=0.
  - Every other active voice increments its age, saturating at 2^(IDX_W+1)-1.
- Note-off: clears the gate of every active voice with equal frequency; frequency and wave type are retained. No match -> AckDropped=1, AckIndex=0.
- ReqFrequency=0 note-on is invalid (it would stall the oscillator): dropped, AckDropped=1, AckIndex=0.
- ReqWaveType=11 is stored as 00.
- Request inputs are sampled only at acceptance; changes during SCAN are ignored.

Optional Feature:
- VOICE_STEAL_EN defined: a full bank steals the oldest voice as described above.
- Not defined: a note-on with no match and no free slot is dropped (AckDropped=1, AckIndex=0, no state change); AckStolen is tied 0.

Decomposition:
- Package synth_pkg holds:
  - wave type enum: SAW=2'b00, SQUARE=2'b01, TRIANGLE=2'b10, RESERVED=2'b11
  - allocator state enum: IDLE, SCAN, COMMIT
  - age-width helper function
- Sub-module voice_slot (one per voice) holds frequency, wave type, gate and the saturating age counter, with load/clear/age-increment controls. voice_allocator contains the FSM, scan pointer and candidate registers.

Test Plan:
- Reset, then note-on 0x40 saw -> Ack at cycle 5 after acceptance, AckIndex=0; from cycle 6 VoiceGate=0001, VoiceFrequency[7:0]=0x40.
- Note-on 0x40, 0x50, 0x60, 0x70, then 0x80 with VOICE_STEAL_EN -> 0x80 lands in voice 0, AckStolen=1. Rerun without the macro -> AckDropped=1, gates stay 1111.
- Note-on 0x50 twice with types 00 then 10 -> both Ack AckIndex=0; the second updates the type to 10; VoiceGate=0001.
- With voices 0 and 2 at 0x30, note-off 0x30 -> VoiceGate bits 0 and 2 clear, AckIndex=0; note-off 0x99 -> AckDropped=1.
- Note-on frequency 0, and wave type 11 at 0x20 -> first dropped; second stored as 00.
- Assert ResetN low mid-SCAN -> all outputs 0 immediately, no AckValid; ReqReady=1 one edge after release.
